multicycle_control: RTL and testbench

Multicycle control FSM that sequences the instruction register, register file, ALU, PC and unified memory of the MIPS-subset datapath. Takes the opcode from the instruction register and drives every datapath enable and mux select. Supports R-type, lw, sw, beq, addi and j. Uses a memory ready handshake so the datapath can stall on slow memory.

---
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM. 2-5 cycles per instruction when memory responds immediately.
// Memory backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low. All outputs stay stable during the stall.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IRwrite,
    output logic       PCwrite,
    output logic       PCwritecond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur, nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur <= FETCH;
        end else begin
            cur <= nxt;
        end
    end

    assign state = cur;

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt = EXEC;
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH;
                endcase
            end
            // Anything other than sw falls through to the load path.
            MEMADR: nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWB:  nxt = FETCH;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            EXEC:   nxt = ALUWB;
            ALUWB:  nxt = FETCH;
            BRANCH: nxt = FETCH;
            ADDIEX: nxt = ADDIWB;
            ADDIWB: nxt = FETCH;
            JUMP:   nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        IRwrite     = 1'b0;
        PCwrite     = 1'b0;
        PCwritecond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (cur)
            FETCH: begin
                // PC+4 is computed every FETCH cycle but only committed with the instruction.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRwrite = mem_ready;
                PCwrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCwritecond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                PCwrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
                illegal_op = 1'b0;
            end
        endcase
        // Reset silences every strobe, even before the state register has settled.
        if (!rst) begin
            IRwrite     = 1'b0;
            PCwrite     = 1'b0;
            PCwritecond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state and outputs queued on drive, popped on sample.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IRwrite, PCwrite, PCwritecond, IorD, MemRead, MemWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       rdst;
        logic       rwr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       done;
        logic       ill;
    } outs_t;

    typedef struct packed {
        logic [3:0] st;
        outs_t      o;
    } exp_t;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JP = 6'b000010, IL = 6'b111111;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .IRwrite(IRwrite), .PCwrite(PCwrite), .PCwritecond(PCwritecond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    // Output table written straight from the per-state control description.
    function automatic outs_t exp_outs(input logic [3:0] st, input logic mr, input logic r, input logic [5:0] op);
        outs_t o;
        o = '0;
        case (st)
            4'd0:  begin o.mrd = 1'b1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
            4'd1:  begin
                o.srcb = 2'b11;
                o.ill  = !(op == RT || op == LW || op == SW || op == BQ || op == AD || op == JP);
            end
            4'd2:  begin o.srca = 1'b1; o.srcb = 2'b10; end
            4'd3:  begin o.mrd = 1'b1; o.iord = 1'b1; end
            4'd4:  begin o.rwr = 1'b1; o.m2r = 1'b1; o.done = 1'b1; end
            4'd5:  begin o.mwr = 1'b1; o.iord = 1'b1; o.done = mr; end
            4'd6:  begin o.srca = 1'b1; o.aluop = 2'b10; end
            4'd7:  begin o.rwr = 1'b1; o.rdst = 1'b1; o.done = 1'b1; end
            4'd8:  begin o.srca = 1'b1; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01; o.done = 1'b1; end
            4'd9:  begin o.srca = 1'b1; o.srcb = 2'b10; end
            4'd10: begin o.rwr = 1'b1; o.done = 1'b1; end
            4'd11: begin o.pcw = 1'b1; o.pcsrc = 2'b10; o.done = 1'b1; end
            default: o = '0;
        endcase
        if (!r) o = '0;
        return o;
    endfunction

    // One clock cycle: drive at negedge, queue expectation, sample 1ns later.
    task automatic cyc(input logic r, input logic mr, input logic [5:0] op, input logic [3:0] st, input string tag);
        exp_t  e;
        outs_t got;
        @(negedge clk);
        rst       = r;
        mem_ready = mr;
        opcode    = op;
        sb_q.push_back({st, exp_outs(st, mr, r, op)});
        #1;
        got = {IRwrite, PCwrite, PCwritecond, IorD, MemRead, MemWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};
        e = sb_q.pop_front();
        checks++;
        assert (state === e.st) else begin
            errors++;
            $error("FAIL %s state observed %0d expected %0d", tag, state, e.st);
        end
        checks++;
        assert (got === e.o) else begin
            errors++;
            $error("FAIL %s outputs observed %b expected %b", tag, got, e.o);
        end
    endtask

    initial begin
        rst       = 1'b0;
        mem_ready = 1'b1;
        opcode    = RT;
        @(posedge clk);

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, RT, 4'd0, "reset_hold");

        cyc(1'b1, 1'b1, LW, 4'd0, "lw_fetch");
        cyc(1'b1, 1'b1, LW, 4'd1, "lw_decode");
        cyc(1'b1, 1'b1, LW, 4'd2, "lw_memadr");
        cyc(1'b1, 1'b1, LW, 4'd3, "lw_memrd");
        cyc(1'b1, 1'b1, LW, 4'd4, "lw_memwb");

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, SW, 4'd0, "fetch_stall");
        cyc(1'b1, 1'b1, SW, 4'd0, "fetch_release");
        cyc(1'b1, 1'b1, SW, 4'd1, "sw_decode");
        cyc(1'b1, 1'b1, SW, 4'd2, "sw_memadr");
        cyc(1'b1, 1'b0, SW, 4'd5, "sw_memwr_stall");
        cyc(1'b1, 1'b1, BQ, 4'd5, "sw_memwr");
        cyc(1'b1, 1'b1, BQ, 4'd0, "beq_fetch");
        cyc(1'b1, 1'b1, BQ, 4'd1, "beq_decode");
        cyc(1'b1, 1'b1, RT, 4'd8, "beq_branch");

        cyc(1'b1, 1'b1, RT, 4'd0, "r_fetch");
        cyc(1'b1, 1'b1, RT, 4'd1, "r_decode");
        cyc(1'b1, 1'b1, RT, 4'd6, "r_exec");
        cyc(1'b1, 1'b1, AD, 4'd7, "r_aluwb");

        cyc(1'b1, 1'b1, AD, 4'd0, "addi_fetch");
        cyc(1'b1, 1'b1, AD, 4'd1, "addi_decode");
        cyc(1'b1, 1'b1, AD, 4'd9, "addi_ex");
        cyc(1'b1, 1'b1, JP, 4'd10, "addi_wb");

        cyc(1'b1, 1'b1, JP, 4'd0, "j_fetch");
        cyc(1'b1, 1'b1, JP, 4'd1, "j_decode");
        cyc(1'b1, 1'b1, IL, 4'd11, "j_jump");

        cyc(1'b1, 1'b1, IL, 4'd0, "ill_fetch");
        cyc(1'b1, 1'b1, IL, 4'd1, "ill_decode");
        cyc(1'b1, 1'b1, LW, 4'd0, "ill_return");

        cyc(1'b1, 1'b1, LW, 4'd1, "rst_lw_decode");
        cyc(1'b1, 1'b1, LW, 4'd2, "rst_lw_memadr");
        cyc(1'b1, 1'b0, LW, 4'd3, "memrd_stall");
        cyc(1'b0, 1'b0, LW, 4'd3, "memrd_rst_assert");
        cyc(1'b0, 1'b0, LW, 4'd0, "memrd_rst_state");
        cyc(1'b1, 1'b1, LW, 4'd0, "post_rst_fetch");
        cyc(1'b1, 1'b1, LW, 4'd1, "post_rst_decode");

        checks++;
        assert (sb_q.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
